// File: rtl/vga_plot_arbiter_if.sv
// Pixel-request / pixel-write bundle between the snake game logic and the plot arbiter.
// The master is the game side; the slave is the arbiter that drives the VGA adapter inputs.
interface vga_plot_arbiter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic              clear_start;
  logic [CW-1:0]     clear_colour;
  logic              clear_busy;
  logic [2:0]        req;
  logic [3*XW-1:0]   req_x;
  logic [3*YW-1:0]   req_y;
  logic [3*CW-1:0]   req_colour;
  logic [2:0]        ack;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CW-1:0]     colour;
  logic              plot;

  modport master (
    output clear_start, clear_colour, req, req_x, req_y, req_colour,
    input  clear_busy, ack, x, y, colour, plot
  );

  modport slave (
    input  clear_start, clear_colour, req, req_x, req_y, req_colour,
    output clear_busy, ack, x, y, colour, plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter's single pixel-write port among three
// requesters, plus a built-in raster fill sequencer that owns the port while clearing.
module vga_plot_arbiter #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic               clk,
  input  logic               resetn,
  vga_plot_arbiter_if.slave  bus
);

  localparam logic [XW-1:0] X_LAST = XW'(XMAX);
  localparam logic [YW-1:0] Y_LAST = YW'(YMAX);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_next;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic [CW-1:0]   fill_colour;
  logic [1:0]      last;

  logic            grant;
  logic [1:0]      grant_idx;
  logic [2:0]      ack_c;
  logic [XW-1:0]   g_x;
  logic [YW-1:0]   g_y;
  logic [CW-1:0]   g_colour;
  logic            in_range;

  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   colour_q;
  logic            plot_q;
  logic            busy_q;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Grants only in IDLE with no fill command pending; reset forces ack low.
  always_comb begin : arbitrate
    logic [1:0] cand;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant     = 1'b0;
    grant_idx = 2'd0;
    ack_c     = 3'b000;
    cand      = next_idx(last);
    if (resetn && state == IDLE && !bus.clear_start) begin
      for (int k = 0; k < 3; k++) begin
        if (!grant && bus.req[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
        cand = next_idx(cand);
      end
    end
    if (grant) ack_c[grant_idx] = 1'b1;
  end

  always_comb begin
    g_x      = bus.req_x[grant_idx*XW +: XW];
    g_y      = bus.req_y[grant_idx*YW +: YW];
    g_colour = bus.req_colour[grant_idx*CW +: CW];
    in_range = (g_x <= X_LAST) && (g_y <= Y_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.clear_start) state_next = CLEAR;
      CLEAR: if (cx == X_LAST && cy == Y_LAST) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cx          <= '0;
      cy          <= '0;
      fill_colour <= '0;
      last        <= 2'd2;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state  <= state_next;
      busy_q <= (state_next == CLEAR);
      case (state)
        IDLE: begin
          plot_q <= 1'b0;
          if (bus.clear_start) begin
            cx          <= '0;
            cy          <= '0;
            fill_colour <= bus.clear_colour;
          end else if (grant) begin
            x_q      <= g_x;
            y_q      <= g_y;
            colour_q <= g_colour;
            plot_q   <= in_range;
            last     <= grant_idx;
          end
        end
        CLEAR: begin
          x_q      <= cx;
          y_q      <= cy;
          colour_q <= fill_colour;
          plot_q   <= 1'b1;
          // Explicit compares: XMAX/YMAX need not be the counters' natural wrap point.
          if (cx == X_LAST) begin
            cx <= '0;
            cy <= (cy == Y_LAST) ? '0 : cy + YW'(1);
          end else begin
            cx <= cx + XW'(1);
          end
        end
      endcase
    end
  end

  assign bus.ack        = ack_c;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.clear_busy = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus pushes expected pixels (with the cycle they
// must appear in); a negedge monitor pops and compares every plotted pixel.
module tb_vga_plot_arbiter;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } px_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;
  px_t  sb[$];

  vga_plot_arbiter_if #(.XW(XW), .YW(YW), .CW(CW)) bus();

  vga_plot_arbiter #(.XW(XW), .YW(YW), .CW(CW), .XMAX(159), .YMAX(119)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_px(input int xv, input int yv, input int cv, input int at);
    px_t e;
    e.x = xv; e.y = yv; e.c = cv; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic set_r(input int i, input int xv, input int yv, input int cv);
    bus.req_x[i*XW +: XW]      = XW'(xv);
    bus.req_y[i*YW +: YW]      = YW'(yv);
    bus.req_colour[i*CW +: CW] = CW'(cv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every plot must match the oldest expected pixel, in the expected cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.plot === 1'b1) begin
      if (sb.size() == 0) begin
        check("plot_unexpected", 1, 0);
      end else begin
        px_t e;
        e = sb.pop_front();
        check("plot_x", int'(bus.x), e.x);
        check("plot_y", int'(bus.y), e.y);
        check("plot_colour", int'(bus.colour), e.c);
        check("plot_cycle", cyc, e.cyc);
      end
    end
    if (resetn === 1'b1 && bus.clear_busy === 1'b1) busy_cnt++;
  end

  initial begin
    int c;
    int waited;
    resetn           = 1'b0;
    bus.clear_start  = 1'b0;
    bus.clear_colour = '0;
    bus.req          = '0;
    bus.req_x        = '0;
    bus.req_y        = '0;
    bus.req_colour   = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.req          = 3'($urandom);
      bus.req_x        = 24'($urandom);
      bus.req_y        = 21'($urandom);
      bus.req_colour   = 9'($urandom);
      bus.clear_start  = 1'($urandom);
      bus.clear_colour = 3'($urandom);
      @(negedge clk);
      check("rst_plot", int'(bus.plot), 0);
      check("rst_ack", int'(bus.ack), 0);
      check("rst_busy", int'(bus.clear_busy), 0);
      check("rst_x", int'(bus.x), 0);
      check("rst_y", int'(bus.y), 0);
      check("rst_colour", int'(bus.colour), 0);
      tick();
    end

    // First request after release: requester 0 has priority.
    bus.clear_start = 1'b0;
    bus.req         = 3'b001;
    set_r(0, 5, 7, 3);
    resetn          = 1'b1;
    @(negedge clk);
    check("first_ack", int'(bus.ack), 1);
    push_px(5, 7, 3, cyc + 1);
    tick();
    bus.req = 3'b000;
    repeat (3) tick();

    // Fresh reset so the rotation starts from requester 0.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    set_r(0, 10, 20, 1);
    set_r(1, 30, 40, 2);
    set_r(2, 50, 60, 4);
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_ack", int'(bus.ack), 1 << (k % 3));
      case (k % 3)
        0: push_px(10, 20, 1, cyc + 1);
        1: push_px(30, 40, 2, cyc + 1);
        default: push_px(50, 60, 4, cyc + 1);
      endcase
      tick();
    end
    bus.req = 3'b000;
    repeat (3) tick();

    // Out-of-range pixels are acked and dropped; last still advances.
    set_r(0, 160, 0, 1);
    bus.req = 3'b001;
    @(negedge clk);
    check("drop_x_ack", int'(bus.ack), 1);
    tick();
    set_r(0, 159, 119, 5);
    set_r(1, 0, 120, 2);
    bus.req = 3'b011;
    @(negedge clk);
    check("drop_x_plot", int'(bus.plot), 0);
    check("drop_y_ack", int'(bus.ack), 2);
    tick();
    bus.req = 3'b001;
    @(negedge clk);
    check("drop_y_plot", int'(bus.plot), 0);
    check("corner_ack", int'(bus.ack), 1);
    push_px(159, 119, 5, cyc + 1);
    tick();
    bus.req = 3'b000;
    repeat (3) tick();

    // Full clear, colour 0, with requester 1 waiting throughout.
    bus.clear_colour = 3'd0;
    bus.clear_start  = 1'b1;
    set_r(1, 7, 8, 6);
    bus.req          = 3'b010;
    @(negedge clk);
    check("clear_start_ack", int'(bus.ack), 0);
    c        = cyc;
    busy_cnt = 0;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        push_px(xx, yy, 0, c + 2 + yy * 160 + xx);
    tick();
    bus.clear_start = 1'b0;
    repeat (100) tick();
    bus.clear_start  = 1'b1;
    bus.clear_colour = 3'd3;
    tick();
    bus.clear_start  = 1'b0;
    waited = 0;
    @(negedge clk);
    while (bus.ack === 3'b000 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check("post_clear_grant_cycle", cyc, c + 1 + 19200);
    check("post_clear_ack", int'(bus.ack), 2);
    push_px(7, 8, 6, cyc + 1);
    tick();
    bus.req = 3'b000;
    repeat (3) tick();
    check("clear_busy_cycles", busy_cnt, 19200);

    // Reset in the middle of a fill.
    bus.clear_colour = 3'd5;
    bus.clear_start  = 1'b1;
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 5000; k++) push_px(k % 160, k / 160, 5, c + 2 + k);
    tick();
    bus.clear_start = 1'b0;
    repeat (5000) @(posedge clk);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midfill_rst_plot", int'(bus.plot), 0);
    check("midfill_rst_busy", int'(bus.clear_busy), 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (50) tick();
    @(negedge clk);
    check("after_rst_busy", int'(bus.clear_busy), 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single pixel-write port of the 160x120 VGA adapter among three drawing requesters (e.g. snake head draw, tail erase, food draw) and a built-in full-screen clear sequencer. Sits between the snake game logic and `vga_adapter`, driving its `x`/`y`/`colour`/`plot` inputs. Arbitration is round-robin, with a one-cycle acknowledge handshake. At most one pixel is plotted per clock.

## Interface
- `XW`, default 8: x coordinate width.
- `YW`, default 7: y coordinate width.
- `CW`, default 3: colour width.
- `XMAX`, default 159: last valid column.
- `YMAX`, default 119: last valid row.

- `clk`  in  1  system clock (CLOCK_50 at top level).
- `resetn`  in  1  reset, asynchronous, active-low.
- `clear_start`  in  1  request a full-screen fill. Sampled only in IDLE.
- `clear_colour`  in  CW  fill colour. Latched with `clear_start`.
- `clear_busy`  out  1  high while the fill is in progress.
- `req`  in  3  per-requester pixel request.
- `req_x`  in  3*XW  requester i uses bits [i*XW +: XW].
- `req_y`  in  3*YW  requester i uses bits [i*YW +: YW].
- `req_colour`  in  3*CW  requester i uses bits [i*CW +: CW].
- `ack`  out  3  one-hot grant. Combinational, valid in the cycle of the grant.
- `x`  out  XW  registered pixel x to the VGA adapter.
- `y`  out  YW  registered pixel y.
- `colour`  out  CW  registered pixel colour.
- `plot`  out  1  registered write enable.

## Operation
- FSM has two states: IDLE and CLEAR.
- IDLE, `clear_start`=1:
  - Next state is CLEAR. `cx`<=0, `cy`<=0, fill colour latched.
  - `ack`=0 this cycle; `clear_start` beats pending requests.
- IDLE, `clear_start`=0, some `req` high:
  - Round-robin search starts at `last`+1 mod 3.
  - The first set requester i gets `ack[i]`=1 (exactly one bit).
  - At the clock edge: `x`/`y`/`colour` <= requester i's fields, `last` <= i.
  - `plot` <= 1 only if x<=XMAX and y<=YMAX. Out-of-range pixels are still acked but dropped (`plot`<=0).
- IDLE, no request: `plot`<=0. `x`/`y`/`colour` hold their values.
- Handshake: a requester holds `req` and its data stable until it sees `ack`. The transfer completes on the edge where `ack` is 1. The requester may keep `req` high with new data the next cycle; there is no bubble.
- CLEAR:
  - Every cycle: `x`<=`cx`, `y`<=`cy`, `colour`<=latched fill colour, `plot`<=1.
  - Scan is raster order: `cx` increments; at XMAX it wraps to 0 and `cy` increments.
  - On the edge that outputs (XMAX,YMAX), the state returns to IDLE.
  - `ack`=0 throughout. `clear_start` is ignored. Requests wait.
- `clear_busy` = (state==CLEAR), registered. It is high for exactly (XMAX+1)*(YMAX+1) = 19200 cycles.
- Reset values: state IDLE, `x`=0, `y`=0, `colour`=0, `plot`=0, `clear_busy`=0, `ack`=0, `cx`=`cy`=0, `last`=2. With `last`=2, requester 0 has first priority.
- Reset mid-CLEAR abandons the fill. No further plots occur until a new command or request.

## Timing
- Request latency: `ack` in cycle t, `plot`/`x`/`y`/`colour` valid in cycle t+1, for one cycle.
- Sustained throughput: 1 pixel/cycle. With all three requesting continuously, grants rotate 0,1,2,0,…
- Clear timing:
  - `clear_start` sampled at edge E0.
  - `clear_busy`=1 from E0 until the edge E19200.
  - `plot`=1 from E1 through E19200, inclusive: 19200 consecutive cycles.
  - First pixel (0,0) appears after E1. Last pixel (159,119) appears after E19200, when the state is already IDLE.
- The first request grant after a fill can occur in the cycle following E19200. Its plot follows the last fill pixel back-to-back.
- Counter widths: `cx` is XW bits, `cy` is YW bits. Compare against XMAX/YMAX; never rely on natural wrap.

## Test plan
- Reset: hold `resetn`=0 with random inputs -> `plot`=0, `ack`=0, `clear_busy`=0, `x`=`y`=`colour`=0. After release with `req`=3'b001, x=5, y=7, col=3 -> `ack`=001 that cycle; next cycle `plot`=1, (5,7,3).
- Fairness: `req`=3'b111 held for 6 cycles -> `ack` sequence 001,010,100,001,010,100. `plot` high for 6 consecutive cycles with matching coordinates.
- Clear: pulse `clear_start` with colour 0 -> exactly 19200 `plot` cycles, first (0,0), last (159,119), every pixel unique, all colour 0. `clear_busy` high for exactly 19200 cycles.
- Contention: `req[1]` raised mid-fill -> `ack` stays 0 until state is IDLE. Then `ack`=010 and its plot immediately follows the (159,119) plot.
- Range drop: request x=160,y=0 -> acked, `plot` stays 0, `last` updated. Same for x=0,y=120. x=159,y=119 -> plotted.
- Reset mid-fill: assert `resetn`=0 at fill pixel 5000 -> `plot`=0 and `clear_busy`=0 immediately (asynchronous). No plots after release without new stimulus.
